sync_rom_64x8: RTL and testbench

- Synchronous read-only lookup table: 64 words x 8 bits, registered output.
- Used as a small constant table (coefficients/patterns) in the fabric; maps to LUTs/registers, not block RAM.
- Contents are fixed at elaboration by a closed-form rule, so the table is deterministic and checkable.

---
 rtl/sync_rom_pkg.sv | 24 ++
 rtl/sync_rom_64x8_rom_table.sv | 81 ++++++++
 rtl/sync_rom_64x8.sv | 25 ++
 tb/tb_sync_rom_64x8.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sync_rom_pkg.sv
// Shared definitions for the 64x8 constant lookup ROM: geometry, content rule
// and the reference content function.
package sync_rom_pkg;

   localparam int unsigned ADDR_W     = 6;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned DEPTH      = 2 ** ADDR_W;
   localparam int unsigned ROM_MULT   = 37;
   localparam int unsigned ROM_OFFSET = 11;

   // Headroom so MULT*addr + OFFSET never overflows before the intended wrap
   localparam int unsigned WIDE_W     = DATA_W + ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   // word[a] = (ROM_MULT*a + ROM_OFFSET) mod 2**DATA_W
   function automatic data_t rom_word(input addr_t a);
      logic [WIDE_W-1:0] wide;
      wide = WIDE_W'(ROM_MULT) * WIDE_W'(a) + WIDE_W'(ROM_OFFSET);
      return DATA_W'(wide);
   endfunction

endpackage

// File: rtl/sync_rom_64x8_rom_table.sv
// Pure combinational address -> word lookup for the 64x8 ROM, written out as
// an explicit table so it maps to plain LUT logic.
module rom_table
   import sync_rom_pkg::*;
(
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] word_c
);

   // Entries follow (37*a + 11) mod 256
   always_comb begin
      word_c = '0;
      case (address)
         6'd0:  word_c = 8'h0B;
         6'd1:  word_c = 8'h30;
         6'd2:  word_c = 8'h55;
         6'd3:  word_c = 8'h7A;
         6'd4:  word_c = 8'h9F;
         6'd5:  word_c = 8'hC4;
         6'd6:  word_c = 8'hE9;
         6'd7:  word_c = 8'h0E;
         6'd8:  word_c = 8'h33;
         6'd9:  word_c = 8'h58;
         6'd10: word_c = 8'h7D;
         6'd11: word_c = 8'hA2;
         6'd12: word_c = 8'hC7;
         6'd13: word_c = 8'hEC;
         6'd14: word_c = 8'h11;
         6'd15: word_c = 8'h36;
         6'd16: word_c = 8'h5B;
         6'd17: word_c = 8'h80;
         6'd18: word_c = 8'hA5;
         6'd19: word_c = 8'hCA;
         6'd20: word_c = 8'hEF;
         6'd21: word_c = 8'h14;
         6'd22: word_c = 8'h39;
         6'd23: word_c = 8'h5E;
         6'd24: word_c = 8'h83;
         6'd25: word_c = 8'hA8;
         6'd26: word_c = 8'hCD;
         6'd27: word_c = 8'hF2;
         6'd28: word_c = 8'h17;
         6'd29: word_c = 8'h3C;
         6'd30: word_c = 8'h61;
         6'd31: word_c = 8'h86;
         6'd32: word_c = 8'hAB;
         6'd33: word_c = 8'hD0;
         6'd34: word_c = 8'hF5;
         6'd35: word_c = 8'h1A;
         6'd36: word_c = 8'h3F;
         6'd37: word_c = 8'h64;
         6'd38: word_c = 8'h89;
         6'd39: word_c = 8'hAE;
         6'd40: word_c = 8'hD3;
         6'd41: word_c = 8'hF8;
         6'd42: word_c = 8'h1D;
         6'd43: word_c = 8'h42;
         6'd44: word_c = 8'h67;
         6'd45: word_c = 8'h8C;
         6'd46: word_c = 8'hB1;
         6'd47: word_c = 8'hD6;
         6'd48: word_c = 8'hFB;
         6'd49: word_c = 8'h20;
         6'd50: word_c = 8'h45;
         6'd51: word_c = 8'h6A;
         6'd52: word_c = 8'h8F;
         6'd53: word_c = 8'hB4;
         6'd54: word_c = 8'hD9;
         6'd55: word_c = 8'hFE;
         6'd56: word_c = 8'h23;
         6'd57: word_c = 8'h48;
         6'd58: word_c = 8'h6D;
         6'd59: word_c = 8'h92;
         6'd60: word_c = 8'hB7;
         6'd61: word_c = 8'hDC;
         6'd62: word_c = 8'h01;
         6'd63: word_c = 8'h26;
      endcase
   end

endmodule

// File: rtl/sync_rom_64x8.sv
// 64x8 synchronous ROM: combinational table lookup followed by a single
// output register with asynchronous active-low clear.
module sync_rom_64x8
   import sync_rom_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] word_c;

   rom_table u_rom_table (
      .address (address),
      .word_c  (word_c)
   );

   // One-cycle read latency; reset clears the output without a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data <= '0;
      else        data <= word_c;
   end

endmodule

// File: tb/tb_sync_rom_64x8.sv
// Directed bench for sync_rom_64x8: scoreboarded reads against rom_word plus
// fixed known-value, latency and asynchronous reset checks.
module tb_sync_rom_64x8;
   import sync_rom_pkg::*;

   logic  clk;
   logic  rst_n;
   addr_t address;
   data_t data;

   data_t exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   sync_rom_64x8 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .address (address),
      .data    (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input data_t obs, input data_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      data_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed empty scoreboard expected one entry", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, data, e);
      end
   endtask

   // Drive address at the negedge, sample 1 time unit after the next posedge
   task automatic read_step(input addr_t a, input string tag);
      @(negedge clk);
      address = a;
      exp_q.push_back(rom_word(a));
      @(posedge clk);
      #1;
      pop_check(tag);
   endtask

   addr_t known_a[5];
   data_t known_d[5];

   initial begin
      known_a[0] = 6'd0;  known_d[0] = 8'h0B;
      known_a[1] = 6'd1;  known_d[1] = 8'h30;
      known_a[2] = 6'd7;  known_d[2] = 8'h0E;
      known_a[3] = 6'd32; known_d[3] = 8'hAB;
      known_a[4] = 6'd63; known_d[4] = 8'h26;

      // Reset held with clock running
      rst_n   = 1'b0;
      address = 6'd5;
      #1;
      check("reset_async", data, 8'h00);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("reset_hold", data, 8'h00);
      end

      // Release between edges: output waits for the next rising edge
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(rom_word(6'd5));
      #1;
      check("release_hold", data, 8'h00);
      @(posedge clk);
      #1;
      pop_check("first_read");
      check("first_read_const", data, 8'hC4);

      // Full sweep
      for (int i = 0; i < int'(DEPTH); i++)
         read_step(addr_t'(i), "sweep");

      // Known table values independent of the package function
      for (int k = 0; k < 5; k++) begin
         read_step(known_a[k], "known_sb");
         check("known_const", data, known_d[k]);
      end

      // Latency: address change at negedge does not reach data before posedge
      read_step(6'd1, "lat_pre");
      @(negedge clk);
      address = 6'd32;
      exp_q.push_back(rom_word(6'd32));
      #1;
      check("lat_hold", data, 8'h30);
      @(posedge clk);
      #1;
      pop_check("lat_post");
      check("lat_post_const", data, 8'hAB);

      // Mid-cycle async reset, no clock edge needed
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_reset", data, 8'h00);
      @(negedge clk);
      rst_n   = 1'b1;
      address = 6'd1;
      exp_q.push_back(rom_word(6'd1));
      #1;
      check("mid_release_hold", data, 8'h00);
      @(posedge clk);
      #1;
      pop_check("mid_reread");
      check("mid_reread_const", data, 8'h30);

      // Repeated address yields identical value every cycle
      for (int r = 0; r < 3; r++)
         read_step(6'd62, "repeat");
      check("repeat_const", data, 8'h01);

      // Several address changes inside one cycle: only the last one counts
      @(negedge clk);
      address = 6'd10;
      #2 address = 6'd20;
      #1 address = 6'd44;
      exp_q.push_back(rom_word(6'd44));
      check("glitch_hold", data, 8'h01);
      @(posedge clk);
      #1;
      pop_check("glitch_read");
      check("glitch_const", data, 8'h67);

      // Address change right after the edge leaves data untouched
      #1 address = 6'd0;
      #1;
      check("post_edge_stable", data, 8'h67);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
